// File: rtl/aw_spi_chain_tx.sv
// SPI mode-0 master shift engine for MSB-first daisy-chain frames.
// One framed transfer per accepted packet; MISO is captured in parallel.
module aw_spi_chain_tx #(
    parameter int N        = 4,
    parameter int DIV      = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4,
    parameter int LEN_W    = 10,
    localparam int MAXB    = N * 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAXB-1:0]   in_frame,
    input  logic [LEN_W-1:0]  in_len,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              busy,
    output logic              done,
    output logic [MAXB-1:0]   rx_data
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [LEN_W-1:0] bits;
    logic             phase;
    logic [MAXB-1:0]  tx_sh;
    logic [MAXB-1:0]  rx_sh;
    logic [LEN_W-1:0] len_eff;

    always_comb begin
        len_eff = in_len;
        if (int'(in_len) > MAXB) begin
            len_eff = LEN_W'(MAXB);
        end
    end

    assign in_ready = (state == IDLE);

    // tx_sh holds the bits still to be sent, already advanced past the one on mosi
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= '0;
            phase    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        tx_sh <= {in_frame[MAXB-2:0], 1'b0};
                        rx_sh <= '0;
                        bits  <= len_eff;
                        phase <= 1'b0;
                        if (len_eff == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            spi_cs_n <= 1'b0;
                            spi_sclk <= 1'b0;
                            spi_mosi <= in_frame[MAXB-1];
                            busy     <= 1'b1;
                            cnt      <= CW'(CS_SETUP - 1);
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= SHIFT;
                        phase <= 1'b0;
                        cnt   <= CW'(DIV - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!phase) begin
                        spi_sclk <= 1'b1;
                        phase    <= 1'b1;
                        rx_sh    <= {rx_sh[MAXB-2:0], spi_miso};
                        cnt      <= CW'(DIV - 1);
                    end else begin
                        spi_sclk <= 1'b0;
                        phase    <= 1'b0;
                        if (bits == LEN_W'(1)) begin
                            state <= HOLD;
                            cnt   <= CW'(CS_HOLD - 1);
                        end else begin
                            bits     <= bits - 1'b1;
                            spi_mosi <= tx_sh[MAXB-1];
                            tx_sh    <= {tx_sh[MAXB-2:0], 1'b0};
                            cnt      <= CW'(DIV - 1);
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state    <= GAP;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                        rx_data  <= rx_sh;
                        cnt      <= CW'(CS_IDLE - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aw_spi_chain_tx.sv
// Directed bench for aw_spi_chain_tx with MISO looped back to MOSI.
// Expected MOSI bits are queued at drive time and popped on each SCLK rise.
module tb_aw_spi_chain_tx;

    localparam int N        = 4;
    localparam int DIV      = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
    localparam int LEN_W    = 10;
    localparam int MAXB     = N * 60;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [MAXB-1:0]  in_frame = '0;
    logic [LEN_W-1:0] in_len = '0;
    logic             spi_cs_n;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;
    logic             busy;
    logic             done;
    logic [MAXB-1:0]  rx_data;

    aw_spi_chain_tx #(
        .N(N), .DIV(DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
        .CS_IDLE(CS_IDLE), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_frame(in_frame), .in_len(in_len), .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .busy(busy), .done(done), .rx_data(rx_data)
    );

    assign spi_miso = spi_mosi;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    int pulses = 0;
    int first_pc = -1;
    int cs_low = 0;
    int done_cnt = 0;
    logic prev_sclk = 1'b0;
    logic [MAXB-1:0] model_rx = '0;

    task automatic chk(input string tag, input logic [MAXB-1:0] obs,
                       input logic [MAXB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every SCLK rise pops one expected MOSI bit
    always begin
        bit e;
        @(posedge clk);
        #1;
        if (spi_sclk && !prev_sclk) begin
            pulses++;
            if (first_pc < 0) first_pc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL extra_pulse: observed pulse %0d expected none", pulses);
            end else begin
                e = exp_q.pop_front();
                assert (spi_mosi === e) else begin
                    errors++;
                    $error("FAIL mosi_bit: observed %0b expected %0b at pulse %0d",
                           spi_mosi, e, pulses);
                end
            end
        end
        if (!spi_cs_n) cs_low++;
        if (done) done_cnt++;
        prev_sclk = spi_sclk;
    end

    function automatic int eff_len(input int len);
        return (len > MAXB) ? MAXB : len;
    endfunction

    function automatic int span(input int l);
        return (l == 0) ? 0 : CS_SETUP + 2 * DIV * l + CS_HOLD;
    endfunction

    task automatic drive(input logic [MAXB-1:0] frame, input int len,
                         input bit hold, output int t0);
        int n = 0;
        int l = eff_len(len);
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", MAXB'(in_ready), MAXB'(1));
        for (int i = 0; i < l; i++) exp_q.push_back(frame[MAXB-1-i]);
        pulses = 0;
        first_pc = -1;
        cs_low = 0;
        done_cnt = 0;
        in_valid = 1'b1;
        in_frame = frame;
        in_len = LEN_W'(len);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", MAXB'(done), MAXB'(1));
        dc = cyc;
    endtask

    task automatic check_xfer(input string tag, input logic [MAXB-1:0] frame,
                              input int len, input int t0, input int dc);
        int l = eff_len(len);
        chk({tag, "_done_cyc"}, MAXB'(dc - t0), MAXB'(span(l)));
        chk({tag, "_pulses"}, MAXB'(pulses), MAXB'(l));
        chk({tag, "_cs_low"}, MAXB'(cs_low), MAXB'(span(l)));
        if (l > 0) begin
            chk({tag, "_first_sclk"}, MAXB'(first_pc - t0), MAXB'(CS_SETUP + DIV));
            model_rx = frame >> (MAXB - l);
        end else begin
            chk({tag, "_zero_ready"}, MAXB'(in_ready), MAXB'(1));
        end
        chk({tag, "_rx"}, rx_data, model_rx);
        chk({tag, "_q_empty"}, MAXB'(exp_q.size()), MAXB'(0));
    endtask

    task automatic run(input string tag, input logic [MAXB-1:0] frame, input int len);
        int t0;
        int dc;
        drive(frame, len, 1'b0, t0);
        wait_done(dc);
        check_xfer(tag, frame, len, t0, dc);
        @(negedge clk);
        chk({tag, "_done_width"}, MAXB'(done), MAXB'(0));
    endtask

    initial begin
        logic [MAXB-1:0] fa;
        logic [MAXB-1:0] fb;
        logic [MAXB-1:0] fr;
        int t0;
        int da;
        int db;
        int hi;
        int n;

        repeat (3) @(negedge clk);
        chk("reset_outs", MAXB'({spi_cs_n, spi_sclk, spi_mosi, busy, done, in_ready}),
            MAXB'(6'b100001));
        chk("reset_rx", rx_data, '0);
        rst = 1'b0;
        @(negedge clk);

        fa = {60'hA5F_0123_4567_89AB, 180'h0};
        run("single", fa, 60);

        fa = {60'h123_4567_89AB_CDEF, 60'hFED_CBA9_8765_4321,
              60'h0F0_F0F0_F0F0_F0F0, 60'h5A5_A5A5_A5A5_A5A5};
        run("chain", fa, 240);

        fa = {2'b11, 60'h0_FFF_0000_1234, {89{2'b10}}};
        run("bcast", fa, 62);

        fa = {60'h777_0000_1111_2222, 180'h3};
        run("zero", fa, 0);

        fr = '0;
        for (int i = 0; i < 8; i++) fr = (fr << 32) | MAXB'($urandom);
        run("over", fr, 300);

        fa = {60'hC3C_3C3C_0F0F_1234, 180'h0};
        fb = {60'h1E1_E1E1_F00D_BEEF, 180'h0};
        drive(fa, 60, 1'b1, t0);
        in_frame = fb;
        in_len = LEN_W'(60);
        for (int i = 0; i < 60; i++) exp_q.push_back(fb[MAXB-1-i]);
        wait_done(da);
        chk("b2b_a_done_cyc", MAXB'(da - t0), MAXB'(span(60)));
        chk("b2b_a_pulses", MAXB'(pulses), MAXB'(60));
        model_rx = fa >> (MAXB - 60);
        chk("b2b_a_rx", rx_data, model_rx);
        pulses = 0;
        first_pc = -1;
        cs_low = 0;
        hi = 0;
        n = 0;
        while (!in_ready && n < 50) begin
            if (spi_cs_n) hi++;
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_gap", MAXB'(cyc - da), MAXB'(CS_IDLE));
        if (spi_cs_n) hi++;
        @(negedge clk);
        in_valid = 1'b0;
        t0 = cyc;
        chk("b2b_cs_gap", MAXB'(hi >= CS_IDLE), MAXB'(1));
        chk("b2b_accept", MAXB'(t0 - da), MAXB'(CS_IDLE + 1));
        wait_done(db);
        check_xfer("b2b_b", fb, 60, t0, db);
        @(negedge clk);

        fa = {60'h9F8_7E6D_5C4B_3A29, 180'h0};
        drive(fa, 60, 1'b0, t0);
        n = 0;
        while (pulses < 30 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach30", MAXB'(pulses), MAXB'(30));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", MAXB'({spi_cs_n, spi_sclk, spi_mosi, busy, done, in_ready}),
            MAXB'(6'b100001));
        chk("rst_mid_rx", rx_data, '0);
        rst = 1'b0;
        exp_q.delete();
        model_rx = '0;
        repeat (10) @(negedge clk);
        chk("rst_no_done", MAXB'(done_cnt), MAXB'(0));
        chk("rst_no_pulses", MAXB'(pulses), MAXB'(30));

        fa = {60'h0DE_ADBE_EF01_2345, 180'h0};
        run("post_rst", fa, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aw_spi_chain_tx.md
Name: aw_spi_chain_tx

Overview:
- SPI master shift engine that consumes MSB-first daisy-chain frames and drives them onto the SPI pins.
- Frames come from the 60b serial builder, the chain concatenator, or the 62b broadcast builder.
- Sits directly downstream of the packet builders and upstream of the device pads.
- Runs one framed transfer per accepted packet and captures MISO in parallel, so readback data is available at the end of the transfer.

Parameters:
- N, 4, number of daisy-chained ICs; MAXB = N*60 is the frame buffer width.
- DIV, 4, SCLK half-period in clk cycles; must be >= 1.
- CS_SETUP, 2, clk cycles from cs_n falling to the first SCLK low phase.
- CS_HOLD, 2, clk cycles from the last SCLK falling edge to cs_n rising.
- CS_IDLE, 4, minimum clk cycles cs_n stays high between transfers.
- LEN_W, 10, width of the bit-count input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  frame request.
- in_ready  out  1  engine can accept a frame.
- in_frame  in  MAXB  frame, left-aligned MSB-first; first bit on the wire is in_frame[MAXB-1].
- in_len  in  LEN_W  number of bits to shift (60, 62, N*60, ...).
- spi_cs_n  out  1  chip select, active low.
- spi_sclk  out  1  SPI clock, mode 0 (idle low).
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in, already synchronised.
- busy  out  1  high from accept until in_ready returns.
- done  out  1  one-cycle pulse at the end of a transfer.
- rx_data  out  MAXB  captured MISO bits, right-aligned; last bit received at [0].

Behaviour:
- All outputs are registered except in_ready, which is decoded from state.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rx_data=0, state=IDLE (so in_ready=1).
- Handshake: accept occurs on the edge where in_valid && in_ready. in_frame and in_len are latched at that edge and ignored afterwards. in_ready=1 only in IDLE.
- Length rules:
  - in_len > MAXB is clamped to MAXB.
  - in_len == 0: accepted, no CS activity, done pulses on the next cycle, rx_data is unchanged, and the engine returns directly to IDLE with no CS_IDLE gap.
- States IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP, entered at accept edge T0:
  - From T0+1: cs_n=0, sclk=0, mosi=frame[MAXB-1].
  - Lasts CS_SETUP cycles.
- SHIFT:
  - Each bit is DIV cycles with sclk low, then DIV cycles with sclk high.
  - On each rising SCLK: rx shift register <= {rx[MAXB-2:0], spi_miso}.
  - On each falling SCLK except after the last bit: mosi takes the next frame bit.
  - mosi is stable for the whole bit.
  - A bit counter counts down from len. When the last bit's high phase ends, sclk=0 and the engine enters HOLD.
- HOLD: CS_HOLD cycles with cs_n=0, sclk=0, mosi holding the last bit.
- GAP:
  - On entry: cs_n=1, mosi=0, done=1 for exactly one cycle, and rx_data is updated from the rx shift register.
  - Stays CS_IDLE cycles, then goes to IDLE.
  - busy drops together with in_ready rising.
- Timing for len = L > 0:
  - First rising SCLK at T0+1+CS_SETUP+DIV.
  - done asserted in cycle T0+1+CS_SETUP+2*DIV*L+CS_HOLD.
  - in_ready returns CS_IDLE cycles after done.
- rx_data: bits beyond L in the MAXB field are zero. The rx shift register is cleared at accept.
- Reset mid-transfer takes effect on the next edge and applies the reset values. cs_n rises immediately, no done is generated, and the partial rx data is discarded.
- in_valid held high while busy has no effect. The held request is accepted on the first IDLE cycle.

Test Plan:
- Single-IC frame: N=1, DIV=2, frame 60'hA5F_0123_4567_89AB, len=60 -> 60 SCLK pulses of 4 clk each; MOSI sampled on rising edges reproduces the frame MSB-first; done at T0+1+2+240+2=T0+245; cs_n low for exactly 244 cycles.
- Full chain: N=4, len=240, each 60b slice a distinct pattern, MISO looped to MOSI -> 240 pulses; rx_data equals the transmitted frame; done pulse width is 1.
- Broadcast: N=4, len=62, in_frame[239:178]={2'b11,60'h0_FFF_0000_1234} -> exactly 62 pulses; bits below position 178 never appear on MOSI; rx_data[239:62]=0.
- Zero length, then overlength: len=0 -> no cs_n activity and done at T0+1; len=300 with N=4 -> exactly 240 pulses.
- Back-to-back: in_valid held high with two frames -> second accept occurs CS_IDLE=4 cycles after the first done; cs_n is high for at least 4 cycles between the frames.
- Reset mid-frame: rst asserted after bit 30 of 60 -> next edge gives cs_n=1, sclk=0, mosi=0, busy=0, in_ready=1, no done; a fresh frame afterwards transmits correctly.
